alu_operand_fetch: RTL and testbench

//  Upstream feeder of one stateful ALU lane: accepts an (action, PHV) pair, decodes the 25-bit action word and

---
 rtl/alu_operand_fetch_if.sv | 13 +
 rtl/alu_operand_fetch.sv | 130 +++++++++++++
 tb/tb_alu_operand_fetch.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_fetch_if.sv
// Upstream action/PHV handshake into one ALU lane's operand-fetch stage.
interface alu_operand_fetch_if #(
  parameter int NUM_CONT   = 8,
  parameter int ACTION_LEN = 25
);
  logic [ACTION_LEN-1:0]  action_in;
  logic [NUM_CONT*32-1:0] phv_in;
  logic                   in_valid;
  logic                   in_ready;

  modport master (output action_in, phv_in, in_valid, input in_ready);
  modport slave  (input action_in, phv_in, in_valid, output in_ready);
endinterface

// File: rtl/alu_operand_fetch.sv
// Decodes an action word, selects ALU operands from the PHV/immediate, looks up the tenant
// page-table entry and issues everything to the ALU as a one-cycle pulse gated by alu_ready.
module alu_operand_fetch #(
  parameter int NUM_CONT     = 8,
  parameter int CONTAINER_ID = 0,
  parameter int ACTION_LEN   = 25,
  parameter int DATA_WIDTH   = 32,
  parameter int VID_LSB      = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_operand_fetch_if.slave    up,
  input  logic                  cfg_wr_en,
  input  logic [3:0]            cfg_wr_addr,
  input  logic [15:0]           cfg_wr_data,
  output logic [ACTION_LEN-1:0] action_out,
  output logic                  action_valid,
  output logic [DATA_WIDTH-1:0] operand_1_out,
  output logic [DATA_WIDTH-1:0] operand_2_out,
  output logic [DATA_WIDTH-1:0] operand_3_out,
  output logic [15:0]           page_tbl_out,
  output logic                  page_tbl_valid,
  input  logic                  alu_ready
);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_e;

  state_e state_q, state_d;
  logic   accept, issue;

  logic [3:0]            opcode;
  logic [4:0]            src1, src2;
  logic [15:0]           imm16;
  logic [3:0]            vid;
  logic [DATA_WIDTH-1:0] cont1, cont2, imm_zx, imm_sh;
  logic [DATA_WIDTH-1:0] op1_d, op2_d, op3_d;

  logic [ACTION_LEN-1:0] action_q;
  logic [DATA_WIDTH-1:0] op1_q, op2_q, op3_q;
  logic [15:0]           pt_out_q;
  logic [15:0]           pt_q [16];

  assign opcode = up.action_in[24:21];
  assign src1   = up.action_in[20:16];
  assign src2   = up.action_in[15:11];
  assign imm16  = up.action_in[15:0];
  assign vid    = up.phv_in[VID_LSB +: 4];
  assign imm_zx = DATA_WIDTH'(imm16);
  assign imm_sh = DATA_WIDTH'(imm16[4:0]);
  assign op3_d  = DATA_WIDTH'(up.phv_in[CONTAINER_ID*32 +: 32]);

  // Out-of-range container indices fall through the loop and read as zero.
  always_comb begin
    cont1 = '0;
    cont2 = '0;
    for (int unsigned k = 0; k < NUM_CONT; k++) begin
      if (32'(src1) == k) cont1 = DATA_WIDTH'(up.phv_in[k*32 +: 32]);
      if (32'(src2) == k) cont2 = DATA_WIDTH'(up.phv_in[k*32 +: 32]);
    end
  end

  always_comb begin
    op1_d = '0;
    op2_d = '0;
    case (opcode)
      4'b0001, 4'b0010, 4'b0101, 4'b0110: begin op1_d = cont1;  op2_d = cont2;  end
      4'b1001, 4'b1010:                   begin op1_d = cont1;  op2_d = imm_zx; end
      4'b1000, 4'b0100:                   begin op1_d = cont1;  op2_d = imm_sh; end
      4'b0011:                            begin op1_d = imm_zx; op2_d = imm_sh; end
      4'b1011, 4'b0111:                   begin op1_d = '0;     op2_d = imm_sh; end
      4'b1110:                            begin op1_d = '0;     op2_d = imm_zx; end
      default:                            begin op1_d = '0;     op2_d = '0;     end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    issue   = 1'b0;
    case (state_q)
      IDLE:  if (up.in_valid) begin accept = 1'b1; state_d = ISSUE; end
      ISSUE: if (alu_ready)   begin issue  = 1'b1; state_d = HOLD;  end
      HOLD:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign up.in_ready = (state_q == IDLE);
  // The pulse is combinational on ISSUE so latency stays at one cycle; rst_n masks it
  // so a reset arriving in ISSUE never leaks an issue.
  assign action_valid   = issue & rst_n;
  assign page_tbl_valid = issue & rst_n;

  // Lookup in the accept block reads the pre-edge table, so a same-cycle write is not seen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 16; i++) pt_q[i] <= '0;
    end else if (cfg_wr_en) begin
      pt_q[cfg_wr_addr] <= cfg_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      action_q <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      op3_q    <= '0;
      pt_out_q <= '0;
    end else if (accept) begin
      action_q <= up.action_in;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      op3_q    <= op3_d;
      pt_out_q <= pt_q[vid];
    end
  end

  assign action_out    = action_q;
  assign operand_1_out = op1_q;
  assign operand_2_out = op2_q;
  assign operand_3_out = op3_q;
  assign page_tbl_out  = pt_out_q;

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Directed bench for alu_operand_fetch: opcode/operand table plus handshake, hazard and reset sequences.
module tb_alu_operand_fetch;
  localparam int NUM_CONT   = 8;
  localparam int ACTION_LEN = 25;
  localparam int DW         = 32;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  cfg_wr_en;
  logic [3:0]            cfg_wr_addr;
  logic [15:0]           cfg_wr_data;
  logic [ACTION_LEN-1:0] action_out;
  logic                  action_valid;
  logic [DW-1:0]         operand_1_out, operand_2_out, operand_3_out;
  logic [15:0]           page_tbl_out;
  logic                  page_tbl_valid;
  logic                  alu_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_operand_fetch_if #(.NUM_CONT(NUM_CONT), .ACTION_LEN(ACTION_LEN)) up ();

  alu_operand_fetch #(
    .NUM_CONT(NUM_CONT), .CONTAINER_ID(0), .ACTION_LEN(ACTION_LEN), .DATA_WIDTH(DW), .VID_LSB(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .up(up),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .action_out(action_out), .action_valid(action_valid),
    .operand_1_out(operand_1_out), .operand_2_out(operand_2_out), .operand_3_out(operand_3_out),
    .page_tbl_out(page_tbl_out), .page_tbl_valid(page_tbl_valid), .alu_ready(alu_ready)
  );

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  src1;
    logic [15:0] imm;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t        vecs[15];
  logic [31:0] cval[8];
  int          pulses[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] mk_phv(input logic [3:0] vid);
    logic [255:0] p;
    for (int k = 0; k < 8; k++) p[k*32 +: 32] = cval[k];
    p[3:0] = vid;
    return p;
  endfunction

  task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
    cfg_wr_en = 1'b1; cfg_wr_addr = a; cfg_wr_data = d;
    step();
    cfg_wr_en = 1'b0;
  endtask

  // Ends at posedge+1 with the DUT in IDLE.
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!up.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!up.in_ready) chk("wait_idle_timeout", 32'(up.in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [24:0] act, input logic rdy);
    up.action_in = act;
    alu_ready    = rdy;
    up.in_valid  = 1'b1;
    step();
    up.in_valid  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [24:0] a;
    rst_n = 1'b0; cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0; alu_ready = 1'b0;
    up.in_valid = 1'b0; up.action_in = '0;
    cval = '{32'hA0A0_0000, 32'h0000_0011, 32'h0000_0005, 32'hDEAD_BEEF,
             32'h0000_0100, 32'h7FFF_FFFF, 32'h8000_0000, 32'h1234_5678};
    up.phv_in = mk_phv(4'd3);

    vecs[0]  = '{4'b1001, 5'd2,  16'h0007, 32'h0000_0005, 32'h0000_0007}; // addi
    vecs[1]  = '{4'b0001, 5'd1,  16'h1800, 32'h0000_0011, 32'hDEAD_BEEF}; // add c1,c3
    vecs[2]  = '{4'b0010, 5'd7,  16'h2000, 32'h1234_5678, 32'h0000_0100}; // sub c7,c4
    vecs[3]  = '{4'b0101, 5'd5,  16'h3000, 32'h7FFF_FFFF, 32'h8000_0000}; // or c5,c6
    vecs[4]  = '{4'b0110, 5'd9,  16'h1000, 32'h0000_0000, 32'h0000_0005}; // geq src1 out of range
    vecs[5]  = '{4'b1010, 5'd3,  16'hFFFF, 32'hDEAD_BEEF, 32'h0000_FFFF}; // subi
    vecs[6]  = '{4'b1000, 5'd4,  16'hFFE5, 32'h0000_0100, 32'h0000_0005}; // store
    vecs[7]  = '{4'b0011, 5'd1,  16'h8003, 32'h0000_8003, 32'h0000_0003}; // storei
    vecs[8]  = '{4'b1011, 5'd2,  16'h001F, 32'h0000_0000, 32'h0000_001F}; // load
    vecs[9]  = '{4'b0111, 5'd2,  16'h0021, 32'h0000_0000, 32'h0000_0001}; // loadd
    vecs[10] = '{4'b0100, 5'd6,  16'h0042, 32'h8000_0000, 32'h0000_0002}; // ite
    vecs[11] = '{4'b1110, 5'd3,  16'hABCD, 32'h0000_0000, 32'h0000_ABCD}; // set
    vecs[12] = '{4'b1111, 5'd1,  16'h0800, 32'h0000_0000, 32'h0000_0000}; // undefined
    vecs[13] = '{4'b0000, 5'd1,  16'h0800, 32'h0000_0000, 32'h0000_0000}; // undefined
    vecs[14] = '{4'b0001, 5'd31, 16'hF800, 32'h0000_0000, 32'h0000_0000}; // both out of range

    repeat (2) step();
    @(negedge clk);
    chk("rst_in_ready", 32'(up.in_ready), 32'd1);
    chk("rst_action_valid", 32'(action_valid), 32'd0);
    chk("rst_pt_valid", 32'(page_tbl_valid), 32'd0);
    chk("rst_action_out", 32'(action_out), 32'd0);
    chk("rst_op1", operand_1_out, 32'd0);
    chk("rst_op3", operand_3_out, 32'd0);
    chk("rst_pt_out", 32'(page_tbl_out), 32'd0);
    step();
    rst_n = 1'b1;

    cfg_write(4'd3, 16'h0A04);

    for (int i = 0; i < 15; i++) begin
      wait_idle();
      a = {vecs[i].op, vecs[i].src1, vecs[i].imm};
      send(a, 1'b1);
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), 32'(action_valid), 32'd1);
      chk($sformatf("v%0d_pt_valid", i), 32'(page_tbl_valid), 32'd1);
      chk($sformatf("v%0d_in_ready", i), 32'(up.in_ready), 32'd0);
      chk($sformatf("v%0d_action", i), 32'(action_out), 32'(a));
      chk($sformatf("v%0d_op1", i), operand_1_out, vecs[i].e1);
      chk($sformatf("v%0d_op2", i), operand_2_out, vecs[i].e2);
      chk($sformatf("v%0d_op3", i), operand_3_out, 32'hA0A0_0003);
      chk($sformatf("v%0d_pt", i), 32'(page_tbl_out), 32'h0A04);
      step();
      @(negedge clk);
      chk($sformatf("v%0d_hold_valid", i), 32'(action_valid), 32'd0);
      step();
    end

    // Stall in ISSUE with alu_ready low, then release.
    wait_idle();
    send({4'b0010, 5'd7, 16'h2000}, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_in_ready", c), 32'(up.in_ready), 32'd0);
      chk($sformatf("stall%0d_valid", c), 32'(action_valid), 32'd0);
      chk($sformatf("stall%0d_op1", c), operand_1_out, 32'h1234_5678);
      step();
    end
    alu_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_valid", 32'(action_valid), 32'd1);
    chk("stall_release_op2", operand_2_out, 32'h0000_0100);
    step();
    @(negedge clk);
    chk("stall_hold_valid", 32'(action_valid), 32'd0);
    chk("stall_hold_in_ready", 32'(up.in_ready), 32'd0);
    step();
    @(negedge clk);
    chk("stall_back_idle", 32'(up.in_ready), 32'd1);
    step();

    // Continuous in_valid: issues spaced exactly three cycles apart.
    wait_idle();
    up.action_in = {4'b1001, 5'd2, 16'h0007};
    alu_ready = 1'b1;
    up.in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (action_valid) pulses.push_back(k);
      step();
    end
    up.in_valid = 1'b0;
    chk("b2b_pulse_count", 32'(pulses.size()), 32'd3);
    if (pulses.size() > 0) chk("b2b_first_pulse", 32'(pulses[0]), 32'd1);
    for (int k = 1; k < pulses.size(); k++)
      chk($sformatf("b2b_gap%0d", k), 32'(pulses[k] - pulses[k-1]), 32'd3);
    wait_idle();

    // Same-cycle write and lookup of vid1 returns the old entry.
    up.phv_in = mk_phv(4'd1);
    cfg_wr_en = 1'b1; cfg_wr_addr = 4'd1; cfg_wr_data = 16'h1234;
    send({4'b1001, 5'd2, 16'h0007}, 1'b1);
    cfg_wr_en = 1'b0;
    @(negedge clk);
    chk("wr_hazard_valid", 32'(action_valid), 32'd1);
    chk("wr_hazard_old_pt", 32'(page_tbl_out), 32'h0000);
    chk("wr_hazard_op3", operand_3_out, 32'hA0A0_0001);
    wait_idle();
    send({4'b1001, 5'd2, 16'h0007}, 1'b1);
    @(negedge clk);
    chk("wr_hazard_new_pt", 32'(page_tbl_out), 32'h1234);
    wait_idle();

    // Reset while in ISSUE.
    send({4'b0010, 5'd7, 16'h2000}, 1'b0);
    @(negedge clk);
    chk("midrst_in_issue", 32'(up.in_ready), 32'd0);
    rst_n = 1'b0;
    alu_ready = 1'b1;
    #1;
    chk("midrst_no_pulse", 32'(action_valid), 32'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 32'(up.in_ready), 32'd1);
    chk("midrst_valid", 32'(action_valid), 32'd0);
    chk("midrst_pt_out", 32'(page_tbl_out), 32'd0);
    chk("midrst_op1", operand_1_out, 32'd0);
    step();
    send({4'b1001, 5'd2, 16'h0007}, 1'b1);
    @(negedge clk);
    chk("midrst_pt_cleared", 32'(page_tbl_out), 32'd0);
    chk("midrst_op1_after", operand_1_out, 32'h0000_0005);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
